pipe_skid_stage: RTL

Parametrised elastic pipeline stage register for the RV32 core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data payload plus a control field between stages using a valid/ready handshake. In SKID mode it holds up to two entries, so `in_ready` is a pure register output and no combinational ready path crosses the stage. Flush drops all contents, and control bits read as zero whenever the stage is empty, so bubbles can never write registers or memory.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_skid_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for elastic pipeline stage registers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_CTRL_NOP = 0;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Valid/ready pipeline stage, optional two-entry skid, bubble-masked ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_next;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_to_skid;
    logic              w_load_main;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_to_skid  = (r_state == ONE) && w_in_fire && !w_out_fire;
    assign w_load_main = w_in_fire &&
                         ((r_state == EMPTY) || ((r_state == ONE) && w_out_fire));

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) w_state_next = ONE;
                ONE: begin
                    if (w_to_skid)
                        w_state_next = (SKID != 0) ? FULL : ONE;
                    else if (w_out_fire && !w_in_fire)
                        w_state_next = EMPTY;
                end
                FULL:    if (w_out_fire) w_state_next = ONE;
                default: w_state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_main_data <= '0;
                r_main_ctrl <= '0;
            end else if (w_load_main) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if ((r_state == FULL) && w_out_fire) begin
                r_main_data <= w_skid_data;
                r_main_ctrl <= w_skid_ctrl;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic              r_in_ready;

            // Ready is precomputed from the next state so no ready path crosses the stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                    r_in_ready  <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != FULL);
                    if (flush) begin
                        r_skid_data <= '0;
                        r_skid_ctrl <= '0;
                    end else if (w_to_skid) begin
                        r_skid_data <= in_data;
                        r_skid_ctrl <= in_ctrl;
                    end
                end
            end

            assign in_ready    = r_in_ready && !rst;
            assign w_skid_data = r_skid_data;
            assign w_skid_ctrl = r_skid_ctrl;
        end else begin : g_direct
            assign in_ready    = !rst && (!out_valid || out_ready);
            assign w_skid_data = '0;
            assign w_skid_ctrl = '0;
        end
    endgenerate

    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main_data;
    assign out_ctrl  = out_valid ? r_main_ctrl : CTRL_W'(PIPE_CTRL_NOP);
    assign count     = r_state;

endmodule
`default_nettype wire
